// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path: FSM states, default
// geometry, RGB565 colour-bar palette and pixel struct.
package ov7670_pkg;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam int unsigned IMG_W_DEF  = 320;
    localparam int unsigned IMG_H_DEF  = 240;
    localparam int unsigned ADDR_W_DEF = 17;
    localparam int unsigned PIX_W      = 16;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam logic [PIX_W-1:0] C_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] C_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] C_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] C_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] C_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] C_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] C_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] C_BLACK   = 16'h0000;

    // Colour of vertical bar idx, left to right
    function automatic rgb565_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return rgb565_t'(C_WHITE);
            3'd1:    return rgb565_t'(C_YELLOW);
            3'd2:    return rgb565_t'(C_CYAN);
            3'd3:    return rgb565_t'(C_GREEN);
            3'd4:    return rgb565_t'(C_MAGENTA);
            3'd5:    return rgb565_t'(C_RED);
            3'd6:    return rgb565_t'(C_BLUE);
            default: return rgb565_t'(C_BLACK);
        endcase
    endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Registers the camera bus once and derives vsync rise/fall and href fall
// against a second delay stage.
module ov7670_sync_edge (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
    output logic       href_d,
    output logic [7:0] data_d,
    output logic       vsync_rise_c,
    output logic       vsync_fall_c,
    output logic       href_fall_c
);

    logic vsync_d;
    logic vsync_q;
    logic href_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_d <= 1'b0;
            vsync_q <= 1'b0;
            href_d  <= 1'b0;
            href_q  <= 1'b0;
            data_d  <= '0;
        end else begin
            vsync_d <= vsync;
            vsync_q <= vsync_d;
            href_d  <= href;
            href_q  <= href_d;
            data_d  <= data;
        end
    end

    assign vsync_rise_c = vsync_d & ~vsync_q;
    assign vsync_fall_c = ~vsync_d & vsync_q;
    assign href_fall_c  = ~href_d & href_q;

endmodule

// File: rtl/ov7670_capture_memctrl.sv
// OV7670 RGB565 capture into a IMG_W x IMG_H frame buffer, one write per pixel.
// Optional colour-bar source behind OV7670_CAPTURE_TESTPATTERN_EN (adds test_en).
module ov7670_capture_memctrl
    import ov7670_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
`ifdef OV7670_CAPTURE_TESTPATTERN_EN
    input  logic              test_en,
`endif
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int unsigned XW = $clog2(IMG_W + 1);
    localparam int unsigned YW = $clog2(IMG_H + 1);

    logic              href_d;
    logic [7:0]        data_d;
    logic              vsync_rise;
    logic              vsync_fall;
    logic              href_fall;

    state_t            state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] base, base_n;
    logic              phase, phase_n;
    logic [7:0]        upper, upper_n;
    logic              we_n, done_n, err_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [15:0]       wdata_n;
    logic [15:0]       pixel;
    logic [YW-1:0]     y_sat;
    logic [YW-1:0]     y_end;

    ov7670_sync_edge u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .href         (href),
        .data         (data),
        .href_d       (href_d),
        .data_d       (data_d),
        .vsync_rise_c (vsync_rise),
        .vsync_fall_c (vsync_fall),
        .href_fall_c  (href_fall)
    );

`ifdef OV7670_CAPTURE_TESTPATTERN_EN
    assign pixel = test_en ? 16'(bar_colour(3'((32'(x) * 32'd8) / IMG_W)))
                           : {upper, data_d};
`else
    assign pixel = {upper, data_d};
`endif

    // A line only counts once it produced at least one pixel
    assign y_sat = (y < YW'(IMG_H)) ? y + YW'(1) : y;
    assign y_end = (x != '0) ? y_sat : y;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_SYNC;
            x          <= '0;
            y          <= '0;
            base       <= '0;
            phase      <= 1'b0;
            upper      <= '0;
            we         <= 1'b0;
            wAddr      <= '0;
            wData      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            x          <= x_n;
            y          <= y_n;
            base       <= base_n;
            phase      <= phase_n;
            upper      <= upper_n;
            we         <= we_n;
            wAddr      <= waddr_n;
            wData      <= wdata_n;
            frame_done <= done_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        base_n  = base;
        phase_n = phase;
        upper_n = upper;
        we_n    = 1'b0;
        waddr_n = wAddr;
        wdata_n = wData;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            S_SYNC: begin
                if (vsync_rise) state_n = S_VBLANK;
            end
            S_VBLANK: begin
                if (vsync_fall) begin
                    x_n     = '0;
                    y_n     = '0;
                    base_n  = '0;
                    phase_n = 1'b0;
                    state_n = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vsync_rise) begin
                    done_n  = (y_end == YW'(IMG_H));
                    err_n   = (y_end != YW'(IMG_H));
                    state_n = S_VBLANK;
                end else if (href_fall) begin
                    if (x != '0) begin
                        y_n = y_sat;
                        if (y < YW'(IMG_H)) base_n = base + ADDR_W'(IMG_W);
                    end
                    x_n     = '0;
                    phase_n = 1'b0;
                end else if (href_d) begin
                    if (!phase) begin
                        upper_n = data_d;
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (x < XW'(IMG_W)) begin
                            x_n = x + XW'(1);
                            if (y < YW'(IMG_H)) begin
                                we_n    = 1'b1;
                                waddr_n = base + ADDR_W'(x);
                                wdata_n = pixel;
                            end
                        end
                    end
                end
            end
            default: state_n = S_SYNC;
        endcase
    end

endmodule

// File: tb/tb_ov7670_capture_memctrl.sv
// Randomized self-checking bench for ov7670_capture_memctrl on a reduced
// geometry, compared against a pixel-list model of the capture rules.
module tb_ov7670_capture_memctrl;

    localparam int unsigned W  = 40;
    localparam int unsigned H  = 12;
    localparam int unsigned AW = 17;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;
    logic          frame_done;
    logic          frame_err;
`ifdef OV7670_CAPTURE_TESTPATTERN_EN
    logic          test_en = 1'b0;
`endif

    always #5 clk = ~clk;

    ov7670_capture_memctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
`ifdef OV7670_CAPTURE_TESTPATTERN_EN
        .test_en    (test_en),
`endif
        .we         (we),
        .wAddr      (waddr),
        .wData      (wdata),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0] act_addr[$];
    logic [15:0]   act_data[$];
    int            act_cyc[$];
    int            done_cnt = 0;
    int            err_cnt  = 0;

    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_data[$];
    int            line_idx = 0;
    bit            model_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes and pulses away from the active edge
    always @(negedge clk) begin
        if (we === 1'b1) begin
            act_addr.push_back(waddr);
            act_data.push_back(wdata);
            act_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        act_addr.delete();
        act_data.delete();
        act_cyc.delete();
        exp_addr.delete();
        exp_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Drive one href line; the model pairs bytes, clips to W pixels and H lines
    task automatic send_line(input int nbytes, input bit rnd);
        logic [7:0] bytes[$];
        logic [7:0] b;
        int npix;
        for (int i = 0; i < nbytes; i++) begin
            b = rnd ? 8'($urandom) : ((i % 2 == 0) ? 8'hA5 : 8'h5A);
            bytes.push_back(b);
            tick();
            href = 1'b1;
            data = b;
        end
        tick();
        href = 1'b0;
        data = 8'($urandom);
        repeat (3) tick();
        npix = nbytes / 2;
        if (model_en && npix > 0) begin
            if (line_idx < int'(H)) begin
                for (int p = 0; p < npix && p < int'(W); p++) begin
                    exp_addr.push_back(AW'(line_idx * int'(W) + p));
                    exp_data.push_back({bytes[2*p], bytes[2*p+1]});
                end
            end
            line_idx++;
        end
    endtask

    task automatic vsync_pulse();
        tick();
        vsync = 1'b1;
        repeat (5) tick();
        vsync = 1'b0;
        repeat (4) tick();
        line_idx = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vsync   = 1'b0;
        href    = 1'b0;
        data    = 8'h00;
        repeat (3) tick();
        total++; if (we !== 1'b0)       begin bad++; $display("FAIL reset_we got=%b want=0", we); end
        total++; if (waddr !== '0)      begin bad++; $display("FAIL reset_waddr got=%0d want=0", waddr); end
        total++; if (wdata !== 16'h0)   begin bad++; $display("FAIL reset_wdata got=%h want=0000", wdata); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_startup();
        clear_obs();
        model_en = 1'b0;
        for (int l = 0; l < 3; l++) send_line(2 * int'(W), 1'b1);
        model_en = 1'b1;
        total++; if (act_addr.size() != 0) begin bad++; $display("FAIL startup_writes got=%0d want=0", act_addr.size()); end
        total++; if (done_cnt + err_cnt != 0) begin bad++; $display("FAIL startup_pulses got=%0d want=0", done_cnt + err_cnt); end
    endtask

    task automatic test_full_frame();
        vsync_pulse();
        clear_obs();
        for (int l = 0; l < int'(H); l++) send_line(2 * int'(W), 1'b0);
        vsync_pulse();
        total++; if (act_addr.size() != W * H) begin bad++; $display("FAIL full_count got=%0d want=%0d", act_addr.size(), W * H); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (act_addr[i] !== AW'(i) || act_data[i] !== 16'hA55A) begin
                bad++;
                $display("FAIL full_write[%0d] got=%0d/%h want=%0d/a55a", i, act_addr[i], act_data[i], i);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt); end
        total++; if (err_cnt != 0)  begin bad++; $display("FAIL full_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_overlong_odd();
        clear_obs();
        send_line(2 * int'(W) + 60, 1'b1);
        send_line(2 * int'(W) + 1, 1'b1);
        send_line(2 * int'(W), 1'b1);
        send_line(1, 1'b1);
        send_line(0, 1'b1);
        for (int l = 3; l < int'(H); l++) send_line(2 * int'(W), 1'b1);
        vsync_pulse();
        total++; if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL ovl_count got=%0d want=%0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL ovl_write[%0d] got=%0d/%h want=%0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        if (act_addr.size() > W) begin
            total++; if (act_addr[W] !== AW'(W)) begin bad++; $display("FAIL ovl_line1_start got=%0d want=%0d", act_addr[W], W); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ovl_done got=%0d want=1", done_cnt); end
        total++; if (err_cnt != 0)  begin bad++; $display("FAIL ovl_err got=%0d want=0", err_cnt); end
    endtask

    task automatic test_short_frame();
        clear_obs();
        for (int l = 0; l < int'(H) / 2; l++) send_line(2 * int'(W), 1'b1);
        vsync_pulse();
        total++; if (err_cnt != 1)  begin bad++; $display("FAIL short_err got=%0d want=1", err_cnt); end
        total++; if (done_cnt != 0) begin bad++; $display("FAIL short_done got=%0d want=0", done_cnt); end
        clear_obs();
        send_line(2 * int'(W), 1'b1);
        vsync_pulse();
        total++; if (act_addr.size() != W) begin bad++; $display("FAIL short_next_count got=%0d want=%0d", act_addr.size(), W); end
        if (act_addr.size() > 0) begin
            total++; if (act_addr[0] !== '0) begin bad++; $display("FAIL short_next_addr got=%0d want=0", act_addr[0]); end
            total++; if (act_data[0] !== exp_data[0]) begin bad++; $display("FAIL short_next_data got=%h want=%h", act_data[0], exp_data[0]); end
        end
    endtask

    task automatic test_random();
        int nlines;
        int ed;
        for (int f = 0; f < 3; f++) begin
            clear_obs();
            nlines = $urandom_range(int'(H) + 2, int'(H) - 2);
            for (int l = 0; l < nlines; l++) send_line($urandom_range(2 * int'(W) + 10, 0), 1'b1);
            ed = (line_idx >= int'(H)) ? 1 : 0;
            vsync_pulse();
            total++; if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", f, act_addr.size(), exp_addr.size()); end
            for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
                total++;
                if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i]) begin
                    bad++;
                    $display("FAIL rnd%0d_write[%0d] got=%0d/%h want=%0d/%h", f, i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
                end
            end
            total++; if (done_cnt != ed)     begin bad++; $display("FAIL rnd%0d_done got=%0d want=%0d", f, done_cnt, ed); end
            total++; if (err_cnt != 1 - ed)  begin bad++; $display("FAIL rnd%0d_err got=%0d want=%0d", f, err_cnt, 1 - ed); end
        end
    endtask

    task automatic test_latency();
        int p;
        clear_obs();
        tick();
        href = 1'b1;
        data = 8'h12;
        tick();
        data = 8'h34;
        p = cyc;
        tick();
        href = 1'b0;
        repeat (4) tick();
        total++; if (act_addr.size() != 1) begin bad++; $display("FAIL lat_count got=%0d want=1", act_addr.size()); end
        if (act_addr.size() > 0) begin
            total++; if (act_cyc[0] != p + 2)    begin bad++; $display("FAIL lat_cycle got=%0d want=%0d", act_cyc[0], p + 2); end
            total++; if (act_data[0] !== 16'h1234) begin bad++; $display("FAIL lat_data got=%h want=1234", act_data[0]); end
            total++; if (act_addr[0] !== '0)      begin bad++; $display("FAIL lat_addr got=%0d want=0", act_addr[0]); end
        end
        vsync_pulse();
        total++; if (err_cnt != 1) begin bad++; $display("FAIL lat_err got=%0d want=1", err_cnt); end
    endtask

    task automatic test_reset_midline();
        logic [7:0] bytes[$];
        logic [7:0] b;
        clear_obs();
        for (int l = 0; l < 3; l++) send_line(2 * int'(W), 1'b1);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            bytes.push_back(b);
            tick();
            href = 1'b1;
            data = b;
        end
        for (int p = 0; p < 5; p++) begin
            exp_addr.push_back(AW'(3 * int'(W) + p));
            exp_data.push_back({bytes[2*p], bytes[2*p+1]});
        end
        tick();
        reset_n = 1'b0;
        data = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        total++; if (we !== 1'b0)     begin bad++; $display("FAIL rst_mid_we got=%b want=0", we); end
        total++; if (waddr !== '0)    begin bad++; $display("FAIL rst_mid_waddr got=%0d want=0", waddr); end
        total++; if (wdata !== 16'h0) begin bad++; $display("FAIL rst_mid_wdata got=%h want=0000", wdata); end
        reset_n = 1'b1;
        model_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            data = 8'($urandom);
        end
        href = 1'b0;
        repeat (3) tick();
        send_line(2 * int'(W), 1'b1);
        send_line(2 * int'(W), 1'b1);
        model_en = 1'b1;
        vsync_pulse();
        for (int l = 0; l < int'(H); l++) send_line(2 * int'(W), 1'b1);
        vsync_pulse();
        total++; if (act_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rst_mid_count got=%0d want=%0d", act_addr.size(), exp_addr.size()); end
        for (int i = 0; i < act_addr.size() && i < exp_addr.size(); i++) begin
            total++;
            if (act_addr[i] !== exp_addr[i] || act_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL rst_mid_write[%0d] got=%0d/%h want=%0d/%h", i, act_addr[i], act_data[i], exp_addr[i], exp_data[i]);
            end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL rst_mid_done got=%0d want=1", done_cnt); end
        total++; if (err_cnt != 0)  begin bad++; $display("FAIL rst_mid_err got=%0d want=0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_full_frame();
        test_overlong_odd();
        test_short_frame();
        test_random();
        test_latency();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
